// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game display path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: blank display code, display-source and arbiter-state enums, status clip helper.
package memgame_pkg;

    localparam logic [4:0] BLANK_CODE = 5'b10000;
    localparam logic [4:0] STAT_MAX   = 5'd15;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_SEQ  = 2'b01,
        SRC_INP  = 2'b10,
        SRC_STAT = 2'b11
    } disp_src_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEQ,
        S_GAP,
        S_INP,
        S_STAT
    } arb_state_e;

    // Status values only have one hex digit available; anything larger shows as F.
    function automatic logic [4:0] clip_status(input logic [4:0] v);
        return (v > STAT_MAX) ? STAT_MAX : v;
    endfunction

endpackage

// File: rtl/display_arbiter_tick_counter.sv
// Counts pulse_tick events with synchronous clear and a terminal-count compare.
// Latency: count registered; done is combinational from the current count and tick.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: Clk, Rst (async active-low), clr, tick, term (terminal count), done.
module tick_counter #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] term,
    output logic         done
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;
    logic [W:0]   cnt_inc;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    // done fires on the tick that brings the count up to term.
    assign cnt_inc = {1'b0, cnt} + (W+1)'(1);
    assign done    = tick && (cnt_inc >= {1'b0, term});

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the single 7-seg digit between sequence playback, switch echo and idle status.
// Latency: all outputs registered; a request is reflected on the display one cycle after sampling.
// Backpressure: seq_req is held by the requester until the one-cycle seq_ack; inp_req is a level.
// Ports: Clk, Rst (async active-low), pulse_tick, seq_req/seq_digit/seq_ack, inp_req/inp_digit,
//        points, level, disp_out (5'b10000 = blank), disp_src, seq_busy.
// Optional: define STATUS_ROTATE_EN to rotate points/level on the display when idle.
module display_arbiter
    import memgame_pkg::*;
#(
    parameter int HOLD_TICKS = 1,
    parameter int GAP_TICKS  = 1,
    parameter int IDLE_TICKS = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       pulse_tick,
    input  logic       seq_req,
    input  logic [4:0] seq_digit,
    output logic       seq_ack,
    input  logic       inp_req,
    input  logic [4:0] inp_digit,
    input  logic [4:0] points,
    input  logic [4:0] level,
    output logic [4:0] disp_out,
    output logic [1:0] disp_src,
    output logic       seq_busy
);

    localparam int MAX_HG = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int MAX_P  = (MAX_HG > IDLE_TICKS) ? MAX_HG : IDLE_TICKS;
    localparam int CW     = $clog2(MAX_P + 1);

`ifdef STATUS_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    arb_state_e    state, state_nxt;
    logic          stat_sel;   // 0: points, 1: level
    logic [CW-1:0] term;
    logic          tc_clr;
    logic          cnt_done;

    // One counter serves hold, gap and idle timing; the terminal value follows the state.
    always_comb begin
        case (state)
            S_SEQ:   term = CW'(HOLD_TICKS);
            S_GAP:   term = CW'(GAP_TICKS);
            default: term = CW'(IDLE_TICKS);
        endcase
    end

    // Cleared on every state change; also held clear during the ack cycle so a tick
    // coinciding with sequence entry is not counted.
    assign tc_clr = (state_nxt != state) || seq_ack;

    tick_counter #(.W(CW)) u_tick_counter (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (tc_clr),
        .tick (pulse_tick),
        .term (term),
        .done (cnt_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (seq_req)                  state_nxt = S_SEQ;
                else if (inp_req)             state_nxt = S_INP;
                else if (ROT_EN && cnt_done)  state_nxt = S_STAT;
            end
            S_SEQ: begin
                if (!seq_ack && cnt_done)     state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (cnt_done)                 state_nxt = S_IDLE;
            end
            S_INP: begin
                if (seq_req)                  state_nxt = S_SEQ;
                else if (!inp_req)            state_nxt = S_IDLE;
            end
            S_STAT: begin
                if (seq_req)                  state_nxt = S_SEQ;
                else if (inp_req)             state_nxt = S_INP;
            end
            default:                          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            disp_out <= BLANK_CODE;
            disp_src <= SRC_NONE;
            seq_ack  <= 1'b0;
            seq_busy <= 1'b0;
            stat_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            seq_ack  <= 1'b0;
            seq_busy <= (state_nxt == S_SEQ) || (state_nxt == S_GAP);
            case (state_nxt)
                S_SEQ: begin
                    // Capture only on entry; the digit is then held while the requester advances.
                    if (state != S_SEQ) begin
                        disp_out <= seq_digit;
                        disp_src <= SRC_SEQ;
                        seq_ack  <= 1'b1;
                    end
                end
                S_INP: begin
                    disp_out <= inp_digit;
                    disp_src <= SRC_INP;
                end
                S_STAT: begin
                    disp_src <= SRC_STAT;
                    if (state != S_STAT) begin
                        stat_sel <= 1'b0;
                        disp_out <= clip_status(points);
                    end else if (pulse_tick) begin
                        stat_sel <= ~stat_sel;
                        disp_out <= clip_status(stat_sel ? points : level);
                    end else begin
                        disp_out <= clip_status(stat_sel ? level : points);
                    end
                end
                default: begin
                    disp_out <= BLANK_CODE;
                    disp_src <= SRC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

    localparam logic [4:0] BLANK = 5'b10000;
`ifdef STATUS_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       pulse_tick = 1'b0;
    logic       seq_req = 1'b0;
    logic [4:0] seq_digit = 5'd0;
    logic       inp_req = 1'b0;
    logic [4:0] inp_digit = 5'd0;
    logic [4:0] points = 5'd0;
    logic [4:0] level = 5'd0;
    logic       seq_ack;
    logic [4:0] disp_out;
    logic [1:0] disp_src;
    logic       seq_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    display_arbiter dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .pulse_tick (pulse_tick),
        .seq_req    (seq_req),
        .seq_digit  (seq_digit),
        .seq_ack    (seq_ack),
        .inp_req    (inp_req),
        .inp_digit  (inp_digit),
        .points     (points),
        .level      (level),
        .disp_out   (disp_out),
        .disp_src   (disp_src),
        .seq_busy   (seq_busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse();
        pulse_tick = 1'b1;
        step();
        pulse_tick = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        pulse_tick = 1'b0; seq_req = 1'b0; inp_req = 1'b0;
        seq_digit = 5'd0; inp_digit = 5'd0; points = 5'd0; level = 5'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL rst_disp: got %h want %h", disp_out, BLANK); end
        n_cmp++; if (disp_src !== 2'b00) begin n_bad++; $display("FAIL rst_src: got %b want 00", disp_src); end
        n_cmp++; if (seq_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", seq_ack); end
        n_cmp++; if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", seq_busy); end
        // Enter S_SEQ, then pull reset mid-cycle with no clock edge.
        seq_digit = 5'd7; seq_req = 1'b1;
        step();
        @(negedge Clk);
        n_cmp++; if (seq_busy !== 1'b1) begin n_bad++; $display("FAIL pre_rst_busy: got %b want 1", seq_busy); end
        #2 Rst = 1'b0;
        #1;
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL async_rst_disp: got %h want %h", disp_out, BLANK); end
        n_cmp++; if (disp_src !== 2'b00) begin n_bad++; $display("FAIL async_rst_src: got %b want 00", disp_src); end
        n_cmp++; if (seq_ack !== 1'b0) begin n_bad++; $display("FAIL async_rst_ack: got %b want 0", seq_ack); end
        n_cmp++; if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy: got %b want 0", seq_busy); end
        seq_req = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_seq_single();
        do_reset();
        seq_digit = 5'd7; seq_req = 1'b1;
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b1) begin n_bad++; $display("FAIL seq_ack: got %b want 1", seq_ack); end
        n_cmp++; if (disp_out !== 5'd7) begin n_bad++; $display("FAIL seq_disp: got %h want 07", disp_out); end
        n_cmp++; if (disp_src !== 2'b01) begin n_bad++; $display("FAIL seq_src: got %b want 01", disp_src); end
        seq_req = 1'b0;
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b0) begin n_bad++; $display("FAIL seq_ack_width: got %b want 0", seq_ack); end
        n_cmp++; if (disp_out !== 5'd7) begin n_bad++; $display("FAIL seq_hold: got %h want 07", disp_out); end
        pulse();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL gap_disp: got %h want %h", disp_out, BLANK); end
        n_cmp++; if (disp_src !== 2'b00) begin n_bad++; $display("FAIL gap_src: got %b want 00", disp_src); end
        step(); step();
        @(negedge Clk);
        n_cmp++; if (seq_busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy: got %b want 1", seq_busy); end
        pulse();
        @(negedge Clk);
        n_cmp++; if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", seq_busy); end
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL idle_disp: got %h want %h", disp_out, BLANK); end
    endtask

    task automatic test_back_to_back();
        int acks;
        do_reset();
        seq_digit = 5'd5; seq_req = 1'b1;
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack1: got %b want 1", seq_ack); end
        n_cmp++; if (disp_out !== 5'd5) begin n_bad++; $display("FAIL b2b_disp1: got %h want 05", disp_out); end
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_noack_hold: got %b want 0", seq_ack); end
        pulse();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL b2b_gap1: got %h want %h", disp_out, BLANK); end
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_noack_gap: got %b want 0", seq_ack); end
        pulse();
        step();
        @(negedge Clk);
        n_cmp++; if (seq_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack2: got %b want 1", seq_ack); end
        n_cmp++; if (disp_out !== 5'd5) begin n_bad++; $display("FAIL b2b_disp2: got %h want 05", disp_out); end
        seq_req = 1'b0;
        step();
        pulse();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL b2b_gap2: got %h want %h", disp_out, BLANK); end
        pulse();
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (seq_ack === 1'b1) acks++;
            step();
        end
        n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL b2b_extra_acks: got %0d want 0", acks); end
    endtask

    task automatic test_seq_inp_simul();
        do_reset();
        seq_digit = 5'd3; seq_req = 1'b1;
        inp_digit = 5'd9; inp_req = 1'b1;
        step();
        @(negedge Clk);
        n_cmp++; if (disp_out !== 5'd3) begin n_bad++; $display("FAIL simul_seq_disp: got %h want 03", disp_out); end
        n_cmp++; if (disp_src !== 2'b01) begin n_bad++; $display("FAIL simul_seq_src: got %b want 01", disp_src); end
        seq_req = 1'b0;
        step();
        pulse();
        @(negedge Clk);
        n_cmp++; if (disp_src !== 2'b00) begin n_bad++; $display("FAIL simul_gap_src: got %b want 00", disp_src); end
        pulse();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL simul_idle_disp: got %h want %h", disp_out, BLANK); end
        step();
        @(negedge Clk);
        n_cmp++; if (disp_out !== 5'd9) begin n_bad++; $display("FAIL simul_inp_disp: got %h want 09", disp_out); end
        n_cmp++; if (disp_src !== 2'b10) begin n_bad++; $display("FAIL simul_inp_src: got %b want 10", disp_src); end
        inp_digit = 5'd4;
        step();
        @(negedge Clk);
        n_cmp++; if (disp_out !== 5'd4) begin n_bad++; $display("FAIL inp_follow: got %h want 04", disp_out); end
        inp_req = 1'b0;
        step();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL inp_release_disp: got %h want %h", disp_out, BLANK); end
        n_cmp++; if (disp_src !== 2'b00) begin n_bad++; $display("FAIL inp_release_src: got %b want 00", disp_src); end
    endtask

    task automatic test_status();
        logic [4:0] exp_d;
        logic [1:0] exp_s;
        do_reset();
        points = 5'd4; level = 5'd5;
        pulse(); pulse();
        @(negedge Clk);
        n_cmp++; if (disp_out !== BLANK) begin n_bad++; $display("FAIL stat_early: got %h want %h", disp_out, BLANK); end
        exp_s = ROT ? 2'b11 : 2'b00;
        pulse();
        @(negedge Clk);
        exp_d = ROT ? 5'd4 : BLANK;
        n_cmp++; if (disp_out !== exp_d) begin n_bad++; $display("FAIL stat_first: got %h want %h", disp_out, exp_d); end
        n_cmp++; if (disp_src !== exp_s) begin n_bad++; $display("FAIL stat_src: got %b want %b", disp_src, exp_s); end
        step();
        @(negedge Clk);
        n_cmp++; if (disp_out !== exp_d) begin n_bad++; $display("FAIL stat_steady: got %h want %h", disp_out, exp_d); end
        pulse();
        @(negedge Clk);
        exp_d = ROT ? 5'd5 : BLANK;
        n_cmp++; if (disp_out !== exp_d) begin n_bad++; $display("FAIL stat_second: got %h want %h", disp_out, exp_d); end
        pulse();
        @(negedge Clk);
        exp_d = ROT ? 5'd4 : BLANK;
        n_cmp++; if (disp_out !== exp_d) begin n_bad++; $display("FAIL stat_third: got %h want %h", disp_out, exp_d); end
        points = 5'd31;
        step();
        @(negedge Clk);
        exp_d = ROT ? 5'd15 : BLANK;
        n_cmp++; if (disp_out !== exp_d) begin n_bad++; $display("FAIL stat_clip: got %h want %h", disp_out, exp_d); end
        inp_digit = 5'd2; inp_req = 1'b1;
        step();
        @(negedge Clk);
        n_cmp++; if (disp_src !== 2'b10) begin n_bad++; $display("FAIL stat_to_inp_src: got %b want 10", disp_src); end
        n_cmp++; if (disp_out !== 5'd2) begin n_bad++; $display("FAIL stat_to_inp_disp: got %h want 02", disp_out); end
        inp_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_seq_single();
        test_back_to_back();
        test_seq_inp_simul();
        test_status();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
